// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: WB-stage RegisterFile write port with long-latency FIFO.
// Define WB_PENDING_MASK_EN to build the pending-write mask.
module reg_writeback_ctrl #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            lu_valid,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_data,
  output logic            lu_ready,
  output logic [4:0]      WriteRegister,
  output logic [XLEN-1:0] WriteData,
  output logic            WriteEnable,
  output logic [31:0]     pending_mask
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    rdPtr, wrPtr;
  logic [CW-1:0]    count;
  logic [4:0]       entRd [DEPTH];
  logic [XLEN-1:0]  entData [DEPTH];
  logic [DEPTH-1:0] entVld, entKill;
  logic [DEPTH-1:0] vldNext, killNext;
  logic             readyEn;
  logic             wbWr, luXfer, luDrop;
  logic             fifoEmpty, headKilled;
  logic             pop, push, bypass, headIssue;
  logic             selV;
  logic [4:0]       selRd;
  logic [XLEN-1:0]  selData;

  assign lu_ready = readyEn && (count < CW'(DEPTH));

  // Pick one write: pipe, then live head, then bypass
  always_comb begin
    wbWr = wb_valid && (wb_rd != 5'd0);
    luXfer = lu_valid && lu_ready;
    luDrop = luXfer && ((lu_rd == 5'd0) ||
             (wbWr && (lu_rd == wb_rd)));
    fifoEmpty = (count == '0);
    headKilled = entKill[rdPtr] ||
                 (wbWr && (entRd[rdPtr] == wb_rd));
    pop = !fifoEmpty && (headKilled || !wbWr);
    headIssue = !fifoEmpty && !wbWr && !headKilled;
    bypass = fifoEmpty && !wbWr && luXfer && !luDrop;
    push = luXfer && !luDrop && !bypass;
    selV = 1'b0;
    selRd = wb_rd;
    selData = wb_data;
    if (wbWr) begin
      selV = 1'b1;
    end else if (headIssue) begin
      selV = 1'b1;
      selRd = entRd[rdPtr];
      selData = entData[rdPtr];
    end else if (bypass) begin
      selV = 1'b1;
      selRd = lu_rd;
      selData = lu_data;
    end
  end

  // Entry valid/kill flags as they will be after this edge
  always_comb begin
    vldNext = entVld;
    killNext = entKill;
    for (int i = 0; i < DEPTH; i++) begin
      if (entVld[i] && wbWr && (entRd[i] == wb_rd))
        killNext[i] = 1'b1;
    end
    if (pop)
      vldNext[rdPtr] = 1'b0;
    if (push) begin
      vldNext[wrPtr] = 1'b1;
      killNext[wrPtr] = 1'b0;
    end
  end

  // Pointers, occupancy and entry flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      readyEn <= 1'b0;
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      entVld <= '0;
      entKill <= '0;
    end else begin
      readyEn <= 1'b1;
      entVld <= vldNext;
      entKill <= killNext;
      if (pop)
        rdPtr <= rdPtr + PW'(1);
      if (push)
        wrPtr <= wrPtr + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  // Entry payload; validity is tracked separately
  always_ff @(posedge clk) begin
    if (push) begin
      entRd[wrPtr] <= lu_rd;
      entData[wrPtr] <= lu_data;
    end
  end

  // Registered write port; address/data hold when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WriteEnable <= 1'b0;
      WriteRegister <= '0;
      WriteData <= '0;
    end else begin
      WriteEnable <= selV;
      if (selV) begin
        WriteRegister <= selRd;
        WriteData <= selData;
      end
    end
  end

`ifdef WB_PENDING_MASK_EN
  logic [31:0] maskNext;

  // Live buffered destinations after this edge
  always_comb begin
    maskNext = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vldNext[i] && !killNext[i]) begin
        if (push && (wrPtr == PW'(i)))
          maskNext[lu_rd] = 1'b1;
        else
          maskNext[entRd[i]] = 1'b1;
      end
    end
  end

  // Pending mask register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pending_mask <= '0;
    else
      pending_mask <= maskNext;
  end
`else
  assign pending_mask = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// tb_reg_writeback_ctrl: directed vectors with a queue-based reference model.
// Build with WB_PENDING_MASK_EN to also check the pending mask contents.
module tb_reg_writeback_ctrl;
  localparam int DEPTH = 4;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wb_valid, lu_valid;
  logic [4:0] wb_rd, lu_rd;
  logic [XLEN-1:0] wb_data, lu_data;
  logic lu_ready, WriteEnable;
  logic [4:0] WriteRegister;
  logic [XLEN-1:0] WriteData;
  logic [31:0] pending_mask;

  always #5 clk = ~clk;

  reg_writeback_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data),
    .lu_ready(lu_ready),
    .WriteRegister(WriteRegister), .WriteData(WriteData),
    .WriteEnable(WriteEnable), .pending_mask(pending_mask)
  );

  int nVec = 0;
  int nBad = 0;
  bit chkEn = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0] rd;
    logic [63:0] d;
    bit k;
  } ent_t;

  ent_t q[$];
  bit alive;
  logic mWE;
  logic [4:0] mWR;
  logic [63:0] mWD;
  logic [31:0] mMask;

  always @(posedge clk or negedge rst) begin : model
    bit wbW, xfer, byp;
    ent_t h, n;
    if (!rst) begin
      q.delete();
      alive = 0;
      mWE = 0;
      mWR = 0;
      mWD = 0;
      mMask = 0;
    end else begin
      wbW = wb_valid && (wb_rd != 0);
      xfer = lu_valid && alive && (q.size() < DEPTH);
      byp = 0;
      mWE = 0;
      if (wbW) begin
        mWE = 1;
        mWR = wb_rd;
        mWD = wb_data;
        foreach (q[i]) if (q[i].rd == wb_rd) q[i].k = 1;
        if (q.size() > 0 && q[0].k) void'(q.pop_front());
      end else if (q.size() > 0) begin
        h = q.pop_front();
        if (!h.k) begin
          mWE = 1;
          mWR = h.rd;
          mWD = h.d;
        end
      end else if (xfer && lu_rd != 0) begin
        mWE = 1;
        mWR = lu_rd;
        mWD = lu_data;
        byp = 1;
      end
      if (xfer && !byp && lu_rd != 0 && !(wbW && lu_rd == wb_rd)) begin
        n.rd = lu_rd;
        n.d = lu_data;
        n.k = 0;
        q.push_back(n);
      end
      mMask = 0;
      foreach (q[i]) if (!q[i].k) mMask[q[i].rd] = 1'b1;
      alive = 1;
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      chk("lu_ready", 64'(lu_ready), 64'(alive && q.size() < DEPTH));
      chk("WriteEnable", 64'(WriteEnable), 64'(mWE));
      chk("WriteRegister", 64'(WriteRegister), 64'(mWR));
      chk("WriteData", WriteData, mWD);
`ifdef WB_PENDING_MASK_EN
      chk("pending_mask", 64'(pending_mask), 64'(mMask));
`else
      chk("pending_mask", 64'(pending_mask), 64'(0));
`endif
    end
  end

  task automatic step(input bit wv, input logic [4:0] wr,
                      input logic [63:0] wd, input bit lv,
                      input logic [4:0] lr, input logic [63:0] ld,
                      output bit acc);
    wb_valid = wv;
    wb_rd = wr;
    wb_data = wd;
    lu_valid = lv;
    lu_rd = lr;
    lu_data = ld;
    #1 acc = lv && lu_ready;
    @(posedge clk);
    #1;
  endtask

  logic [4:0] lr3 [5] = '{5'd2, 5'd3, 5'd4, 5'd6, 5'd7};
  logic [63:0] ld3 [5] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'd7, 64'd9,
                           64'd1, 64'd2};

  initial begin
    bit acc;
    int idx, nw;
    logic [4:0] wrs[$];
    logic [63:0] dats[$];
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
    #1 rst = 0;
    chkEn = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(lu_ready), 64'(0));
    chk("rst_we", 64'(WriteEnable), 64'(0));
    rst = 1;

    step(1, 5'd1, 64'd42, 0, 5'd0, 64'd0, acc);
    chk("t1_we", 64'(WriteEnable), 64'(1));
    chk("t1_wr", 64'(WriteRegister), 64'(1));
    chk("t1_wd", WriteData, 64'd42);
    chk("t1_ready", 64'(lu_ready), 64'(1));

    step(1, 5'd0, 64'd100, 0, 5'd0, 64'd0, acc);
    chk("t2_we", 64'(WriteEnable), 64'(0));
    chk("t2_hold", WriteData, 64'd42);
    step(0, 5'd0, 64'd0, 1, 5'd0, 64'd77, acc);
    chk("t2_acc", 64'(acc), 64'(1));
    chk("t2_lu_we", 64'(WriteEnable), 64'(0));

    idx = 0;
    for (int c = 0; c < 6; c++) begin
      step(1, 5'd5, 64'(100 + c), idx < 5, idx < 5 ? lr3[idx] : 5'd0,
           idx < 5 ? ld3[idx] : 64'd0, acc);
      if (acc) idx++;
      if (c == 3) begin
        chk("t3_full", 64'(lu_ready), 64'(0));
`ifdef WB_PENDING_MASK_EN
        chk("t3_mask", 64'(pending_mask), 64'h5C);
`endif
      end
    end
    chk("t3_accepts", 64'(idx), 64'(4));
    for (int c = 0; c < 12; c++) begin
      step(0, 5'd0, 64'd0, idx < 5, idx < 5 ? lr3[idx] : 5'd0,
           idx < 5 ? ld3[idx] : 64'd0, acc);
      if (acc) idx++;
      if (WriteEnable) begin
        wrs.push_back(WriteRegister);
        dats.push_back(WriteData);
      end
    end
    chk("t3_nwr", 64'(wrs.size()), 64'(5));
    for (int i = 0; i < 5 && i < wrs.size(); i++) begin
      chk("t3_order", 64'(wrs[i]), 64'(lr3[i]));
      chk("t3_data", dats[i], ld3[i]);
    end

    step(1, 5'd1, 64'd5, 1, 5'd9, 64'd11, acc);
    chk("t4_acc", 64'(acc), 64'(1));
`ifdef WB_PENDING_MASK_EN
    chk("t4_mask_set", 64'(pending_mask[9]), 64'(1));
`endif
    step(1, 5'd9, 64'd22, 0, 5'd0, 64'd0, acc);
    chk("t4_wr", 64'(WriteRegister), 64'(9));
    chk("t4_wd", WriteData, 64'd22);
    chk("t4_mask_clr", 64'(pending_mask[9]), 64'(0));
    nw = 0;
    repeat (3) begin
      step(0, 5'd0, 64'd0, 0, 5'd0, 64'd0, acc);
      if (WriteEnable) nw++;
    end
    chk("t4_no_stale", 64'(nw), 64'(0));

    step(0, 5'd0, 64'd0, 1, 5'd8, 64'd99, acc);
    chk("t6_acc", 64'(acc), 64'(1));
    chk("t6_we", 64'(WriteEnable), 64'(1));
    chk("t6_wr", 64'(WriteRegister), 64'(8));
    chk("t6_wd", WriteData, 64'd99);
    chk("t6_ready", 64'(lu_ready), 64'(1));

    for (int c = 0; c < 3; c++)
      step(1, 5'd10, 64'(200 + c), 1, 5'(11 + c), 64'(300 + c), acc);
`ifdef WB_PENDING_MASK_EN
    chk("t5_mask", 64'(pending_mask), 64'h3800);
`endif
    wb_valid = 0;
    lu_valid = 0;
    rst = 0;
    #1;
    chk("t5_we", 64'(WriteEnable), 64'(0));
    chk("t5_ready", 64'(lu_ready), 64'(0));
    chk("t5_mask0", 64'(pending_mask), 64'(0));
    @(posedge clk);
    #1 rst = 1;
    nw = 0;
    repeat (5) begin
      step(0, 5'd0, 64'd0, 0, 5'd0, 64'd0, acc);
      if (WriteEnable) nw++;
    end
    chk("t5_no_stale", 64'(nw), 64'(0));

    for (int c = 0; c < 60; c++)
      step((c % 4) < 2, 5'((c * 7) % 8), 64'(1000 + c),
           (c % 3) != 2, 5'((c * 5 + 1) % 8), 64'(2000 + c), acc);
    repeat (8) step(0, 5'd0, 64'd0, 0, 5'd0, 64'd0, acc);

    chkEn = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
